// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out word converter.
package sipo_pkg;

  // Bit-order selectors for the MSB_FIRST parameter.
  localparam int SIPO_MSB = 1;
  localparam int SIPO_LSB = 0;

  // Width of a counter that must hold the values 0 .. frame.
  function automatic int cnt_w(input int frame);
    return $clog2(frame + 1);
  endfunction

endpackage

// File: rtl/sipo_word.sv
// sipo_word: collects WIDTH qualified serial bits into a word and presents
// it on a one-entry valid/ready output register with a sticky overrun flag.
// Optional macro SIPO_PARITY_EN appends one parity bit to every frame and
// reports a per-word parity error on out_perr.
module sipo_word
  import sipo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = SIPO_MSB,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             out_perr
);

`ifdef SIPO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = cnt_w(FRAME);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             take_data;
  logic             done;
  logic             load;

`ifdef SIPO_PARITY_EN
  logic perr_q, perr_d;
  logic perr_new;
`endif

  // Datapath, counter and output-register next state.
  always_comb begin
    shifted = (MSB_FIRST != 0) ? {sh_q[WIDTH-2:0], in} : {in, sh_q[WIDTH-1:1]};
`ifdef SIPO_PARITY_EN
    // The trailing parity bit is counted but never enters the shift register,
    // so at completion sh_q already holds the full data word.
    take_data = in_valid && (cnt_q != CW'(WIDTH));
    word      = sh_q;
    perr_new  = ((^sh_q) ^ in) != (PARITY_ODD != 0);
`else
    // The completing bit is still in flight, so the word is the shifted value.
    take_data = in_valid;
    word      = shifted;
`endif
    done      = in_valid && (cnt_q == LAST);
    sh_d      = take_data ? shifted : sh_q;
    cnt_d     = cnt_q;
    if (in_valid) cnt_d = done ? '0 : cnt_q + 1'b1;
    // Load into an empty slot, or into one being drained on this same edge.
    load        = done && (!out_valid_q || out_ready);
    out_d       = load ? word : out_q;
    out_valid_d = load || (out_valid_q && !out_ready);
    overrun_d   = overrun_q || (done && out_valid_q && !out_ready);
`ifdef SIPO_PARITY_EN
    perr_d      = load ? perr_new : perr_q;
`endif
  end

  // State registers; reset wins over everything and drops any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q        <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
`ifdef SIPO_PARITY_EN
      perr_q      <= perr_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
`ifdef SIPO_PARITY_EN
  assign out_perr  = perr_q;
`else
  // No parity path: the flag is constant 0 whatever the parity sense.
  assign out_perr  = 1'b0 & (PARITY_ODD != 0);
`endif

endmodule
